// File: rtl/arith_chain_pkg.sv
// Shared constants and the per-stage add/subtract helper for the arith_chain pipeline.
// Optional feature macro: ARITH_CHAIN_SAT_EN (per-stage saturation instead of modulo wrap).
package arith_chain_pkg;

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;
    localparam int   OP_MAX_W = 32;

    // Operands arrive zero-extended from a width-bit value; the result is valid in its low width bits.
    function automatic logic [OP_MAX_W-1:0] stage_op(
        input logic [OP_MAX_W-1:0] a,
        input logic [OP_MAX_W-1:0] k,
        input logic                op,
        input int                  width
    );
        logic [OP_MAX_W:0] full;
        logic [OP_MAX_W:0] mask;
        mask = (33'd1 << width) - 33'd1;
        if (op == OP_SUB) begin
            full = {1'b0, a} - {1'b0, k};
        end else begin
            full = {1'b0, a} + {1'b0, k};
        end
`ifdef ARITH_CHAIN_SAT_EN
        if (op == OP_SUB) begin
            if (k > a) begin
                full = '0;
            end
        end else if (full > mask) begin
            full = mask;
        end
`endif
        full = full & mask;
        return full[OP_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/arith_chain_pipelined_stage.sv
// One arithmetic pipeline register with its valid bit; loads whenever it is empty or draining.
// Saturating vs wrapping arithmetic follows ARITH_CHAIN_SAT_EN through arith_chain_pkg::stage_op.
module arith_chain_stage
    import arith_chain_pkg::*;
#(
    parameter int         W  = 10,
    parameter logic [W-1:0] K  = '0,
    parameter logic       OP = OP_ADD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up_valid_i,
    input  logic [W-1:0] up_data_i,
    input  logic         dn_ready_i,
    output logic         up_ready_o,
    output logic         dn_valid_o,
    output logic [W-1:0] dn_data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] result;

    assign result     = W'(stage_op(OP_MAX_W'(up_data_i), OP_MAX_W'(K), OP, W));
    assign up_ready_o = !valid_q || dn_ready_i;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    // Data only moves on a real transfer so idle cycles do not toggle the register.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (up_ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = result;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/arith_chain_pipelined.sv
// Valid/ready pipeline applying NUM_STAGES constant add/subtract steps to each unsigned sample.
// Build option: define ARITH_CHAIN_SAT_EN for per-stage saturation (default is modulo wrap).
module arith_chain_pipelined
    import arith_chain_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 8,
    parameter int DATA_WIDTH_OUT = 10,
    parameter int NUM_STAGES     = 3,
    parameter logic [NUM_STAGES*DATA_WIDTH_OUT-1:0] K_VEC  = {10'd10, 10'd3, 10'd5},
    parameter logic [NUM_STAGES-1:0]                OP_VEC = 3'b010,
    localparam int OCC_W = $clog2(NUM_STAGES + 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH_IN-1:0]  data_in,
    input  logic                      valid_in,
    output logic                      ready_in,
    output logic [DATA_WIDTH_OUT-1:0] data_out,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [OCC_W-1:0]          occupancy
);

    localparam int W = DATA_WIDTH_OUT;

    // Index j refers to register Rj; dn_rdy[j] is the readiness of whatever follows Rj.
    logic         vld    [NUM_STAGES+1];
    logic [W-1:0] dat    [NUM_STAGES+1];
    logic         dn_rdy [NUM_STAGES+1];

    logic         r0_valid_q, r0_valid_d;
    logic [W-1:0] r0_data_q, r0_data_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic         accept, emit;

    assign vld[0]             = r0_valid_q;
    assign dat[0]             = r0_data_q;
    assign dn_rdy[NUM_STAGES] = ready_out;

    assign ready_in  = !r0_valid_q || dn_rdy[0];
    assign valid_out = vld[NUM_STAGES];
    assign data_out  = dat[NUM_STAGES];
    assign occupancy = occ_q;

    assign accept = valid_in && ready_in;
    assign emit   = valid_out && ready_out;

    always_comb begin
        r0_valid_d = r0_valid_q;
        r0_data_d  = r0_data_q;
        if (ready_in) begin
            r0_valid_d = valid_in;
            if (valid_in) begin
                r0_data_d = W'(data_in);
            end
        end
    end

    // Entries only enter at R0 and leave at the last register, so the count tracks accept/emit.
    always_comb begin
        occ_d = occ_q + OCC_W'(accept) - OCC_W'(emit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0_valid_q <= 1'b0;
            r0_data_q  <= '0;
            occ_q      <= '0;
        end else begin
            r0_valid_q <= r0_valid_d;
            r0_data_q  <= r0_data_d;
            occ_q      <= occ_d;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        arith_chain_stage #(
            .W  (W),
            .K  (K_VEC[g*W +: W]),
            .OP (OP_VEC[g])
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .up_valid_i (vld[g]),
            .up_data_i  (dat[g]),
            .dn_ready_i (dn_rdy[g+1]),
            .up_ready_o (dn_rdy[g]),
            .dn_valid_o (vld[g+1]),
            .dn_data_o  (dat[g+1])
        );
    end

endmodule
